// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: packet-locked round-robin arbiter draining N_IN latency-1 FIFOs into a 2-entry skid queue
// Ports: clk, reset (async, active-high)
//   fifo_empty/fifo_read/fifo_data : upstream FIFOs; data returns the cycle after a read pulse
//   out_valid/out_ready/out_data/out_src : downstream flit stream with source index
//   busy : packet lock held; err_proto : sticky, head flit seen inside a locked packet
module noc_output_arbiter #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 16,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       fifo_empty,
    output logic [N_IN-1:0]       fifo_read,
    input  logic [N_IN*WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_src,
    output logic                  busy,
    output logic                  err_proto
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t            state_q;
    logic [SELW-1:0]   rr_ptr_q, cur_src_q, inf_src_q;
    logic              inf_q, first_q, err_q, rd_q;
    logic [1:0]        cnt_q;
    logic [WIDTH-1:0]  mem_q [2];
    logic [SELW-1:0]   src_q [2];
    logic [WIDTH-1:0]  ret_data;
    logic [SELW-1:0]   nxt_src, pick, rd_src;
    logic              ret_last, ret_err, pop, credit, found, grant_new, grant_lock, rd_en, wr;
    int                start, idx;
    assign ret_data  = fifo_data[int'(inf_src_q)*WIDTH +: WIDTH];
    // type bit 0 set means tail (01) or single (11): the lock ends with this flit
    assign ret_last  = inf_q && ret_data[WIDTH-2];
    assign ret_err   = inf_q && !first_q && ret_data[WIDTH-1 -: 2] == 2'b10;
    assign pop       = out_valid && out_ready;
    // the flit returning this cycle already counts as in flight, so a new read may overlap it
    assign credit    = ({1'b0, cnt_q} + {2'b0, inf_q} - {2'b0, pop}) < 3'd2;
    assign nxt_src   = SELW'((int'(cur_src_q) + 1) % N_IN);
    assign start     = ret_last ? int'(nxt_src) : int'(rr_ptr_q);
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = (start + k) % N_IN;
            // on release the finishing source is excluded so the others get a turn without a bubble
            if (!found && !fifo_empty[idx] && !(ret_last && idx == int'(cur_src_q))) begin
                found = 1'b1;
                pick  = SELW'(idx);
            end
        end
    end
    assign grant_new  = (state_q == IDLE || ret_last) && found && credit;
    assign grant_lock = state_q == LOCKED && !ret_last && !fifo_empty[cur_src_q] && credit;
    assign rd_src     = grant_new ? pick : cur_src_q;
    assign rd_en      = (grant_new || grant_lock) && !reset;
    assign fifo_read  = rd_en ? ({{(N_IN-1){1'b0}}, 1'b1} << rd_src) : '0;
    assign wr         = rd_q ^ cnt_q[0];
    assign out_valid  = cnt_q != 2'd0;
    assign out_data   = mem_q[rd_q];
    assign out_src    = src_q[rd_q];
    assign busy       = state_q == LOCKED;
    assign err_proto  = err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_src_q <= '0;
            inf_src_q <= '0;
            inf_q     <= 1'b0;
            first_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            src_q[0]  <= '0;
            src_q[1]  <= '0;
        end else begin
            if (grant_new) begin
                state_q   <= LOCKED;
                cur_src_q <= pick;
            end else if (ret_last) begin
                state_q <= IDLE;
            end
            if (ret_last) rr_ptr_q <= nxt_src;
            inf_q     <= rd_en;
            inf_src_q <= rd_src;
            first_q   <= grant_new;
            err_q     <= err_q | ret_err;
            if (inf_q) begin
                mem_q[wr] <= ret_data;
                src_q[wr] <= inf_src_q;
            end
            cnt_q <= cnt_q + {1'b0, inf_q} - {1'b0, pop};
            rd_q  <= rd_q ^ pop;
        end
    end
endmodule
